mcore_mem_net_adapter: RTL and testbench
========================================

Name:
mcore_mem_net_adapter

Overview:
- Dual-direction adapter between the memory-message domain and the on-chip network in the multicore memory system.
- Request path: wraps a memory request into a network message, routing by address to a bank and stamping the requester ID into the memory opaque.
- Response path: wraps a memory response into a network message, routing back to the requester ID carried in the opaque.
- Each path has a one-entry registered val/rdy pipeline stage.

Parameters:
- p_net_src, 0: this tile's network ID; becomes the src field and the stamped opaque MSBs.
- p_num_ports, 4: number of network ports (= 2^p_net_srcdest_nbits).
- p_mem_opaque_nbits, 8: memory opaque width (O).
- p_mem_addr_nbits, 32: memory address width (A).
- p_mem_data_nbits, 32: memory data width (D); len width L = clog2(D/8).
- p_net_opaque_nbits, 4: network opaque width (N).
- p_net_srcdest_nbits, 2: network src/dest width (S).
- p_line_offset_nbits, 4: cache-line offset bits; bank select sits just above them.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_in_msg  in  RQ=3+O+A+L+D (77)  memory request {type,opaque,addr,len,data}, MSB→LSB.
- req_in_val  in  1  request valid.
- req_in_rdy  out  1  request ready.
- req_out_msg  out  2S+N+RQ (85)  network message {dest,src,opaque,payload}, MSB→LSB.
- req_out_val  out  1  valid.
- req_out_rdy  in  1  ready.
- resp_in_msg  in  RS=3+O+L+D (45)  memory response {type,opaque,len,data}.
- resp_in_val  in  1  valid.
- resp_in_rdy  out  1  ready.
- resp_out_msg  out  2S+N+RS (53)  network message.
- resp_out_val  out  1  valid.
- resp_out_rdy  in  1  ready.

Behaviour:
- Request translation:
  - dest = addr[p_line_offset_nbits+S-1 : p_line_offset_nbits], i.e. addr[5:4] by default.
  - src = p_net_src.
  - Net opaque = 0.
  - Payload = input request with opaque replaced by {p_net_src[S-1:0], opaque[O-S-1:0]}.
  - type, addr, len and data are copied bit-exactly, including X bits.
- Response translation:
  - dest = opaque[O-1:O-S].
  - src = p_net_src.
  - Net opaque = 0.
  - Payload = input response unchanged.
- Each path has one pipeline register:
  - Transfer occurs when in_val && in_rdy; the message is captured at the clock edge.
  - out_val is asserted the next cycle; latency is 1 cycle.
  - in_rdy = !full || out_rdy (combinational). This gives full throughput with back-to-back transfers.
  - Dequeue happens on out_val && out_rdy.
  - Simultaneous dequeue and enqueue on a full stage replaces the entry; the stage stays full.
- Back-pressure:
  - While out_rdy = 0 and the stage is full, in_rdy = 0.
  - out_msg holds stable while out_val = 1.
- The req and resp paths are fully independent; no ordering between them.
- Reset (reset == 0 at posedge):
  - Both stages become empty; out_val = 0.
  - in_rdy = 1 once reset is deasserted.
  - A message in flight is discarded; an input presented during reset is not accepted.
- out_msg when out_val = 0 is don't-care (register contents).
- A message with X type/addr/opaque yields X dest; it is passed through without checks.
- Translation must be pure bit-slicing/concatenation; no arithmetic.

Test Plan:
- Request routing, p_net_src=2, delivered with out_rdy=1:
  - rd opq 00 addr 00001010 len 0 → dest 1, src 2, payload opaque 80.
  - rd opq 01 addr 00001024 len 1 → dest 2, opaque 81.
  - rd opq 02 addr 00001008 len 2 → dest 0, opaque 82.
  - rd opq 03 addr 0000103c len 3 → dest 3, opaque 83.
  - addr/len/data unchanged in all cases.
- Request writes:
  - wr 10 @00001070 len 0 data abcdef01 → dest 3, opaque 90, data abcdef01.
  - wr 11 @00001064 data xxxxxx01 → dest 2, opaque 91, data preserved.
  - wr 12 @00001068 data xxxxef01 → dest 2, opaque 92.
  - wr 13 @000010fc data xxcdef01 → dest 3, opaque 93.
- Response routing, p_net_src=2:
  - rd opq 00 → dest 0; opq f1 → dest 3; opq 42 → dest 1; opq 83 → dest 2.
  - wr opq 90 data abcdef01 → dest 2.
  - wr opq 51 → dest 1; wr opq 52 → dest 1; wr opq 13 → dest 0.
  - src = 2 in every case; opaque, len and data unchanged.
- Latency/throughput: stream 4 requests back-to-back with out_rdy=1 → out_val rises one cycle after the first in_val. Outputs arrive in order, one per cycle, with no bubbles.
- Back-pressure: hold out_rdy=0 with one entry stored → in_rdy=0 and out_msg stable. Raise out_rdy → dequeue and accept a new message in the same cycle.
- Reset mid-operation: a full stage with reset=0 for one cycle → out_val=0 next cycle. After release in_rdy=1, and the stored message never appears.

Source files
------------

// File: rtl/mcore_mem_net_adapter.sv
// Bridges memory request/response messages onto the on-chip network, with one
// registered val/rdy stage per direction.
module mcore_mem_net_adapter #(
    parameter int p_net_src           = 0,
    parameter int p_num_ports         = 4,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 2,
    parameter int p_line_offset_nbits = 4,
    localparam int O  = p_mem_opaque_nbits,
    localparam int A  = p_mem_addr_nbits,
    localparam int D  = p_mem_data_nbits,
    localparam int L  = $clog2(D / 8),
    localparam int N  = p_net_opaque_nbits,
    localparam int S  = p_net_srcdest_nbits,
    localparam int RQ = 3 + O + A + L + D,
    localparam int RS = 3 + O + L + D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RQ-1:0]      req_in_msg,
    input  logic               req_in_val,
    output logic               req_in_rdy,
    output logic [2*S+N+RQ-1:0] req_out_msg,
    output logic               req_out_val,
    input  logic               req_out_rdy,
    input  logic [RS-1:0]      resp_in_msg,
    input  logic               resp_in_val,
    output logic               resp_in_rdy,
    output logic [2*S+N+RS-1:0] resp_out_msg,
    output logic               resp_out_val,
    input  logic               resp_out_rdy
);

    localparam logic [S-1:0] SRC = S'(p_net_src);

    if (p_num_ports != (1 << p_net_srcdest_nbits)) begin : g_bad_ports
        $error("p_num_ports must equal 2**p_net_srcdest_nbits");
    end

    logic [2*S+N+RQ-1:0] reqMsg_d;
    logic [2*S+N+RQ-1:0] reqMsg_q;
    logic                reqFull_q;
    logic [2*S+N+RS-1:0] respMsg_d;
    logic [2*S+N+RS-1:0] respMsg_q;
    logic                respFull_q;

    // Request: bank chosen by the address bits just above the line offset;
    // the opaque MSBs are overwritten with our ID so the response finds its way back.
    assign reqMsg_d = {
        req_in_msg[L+D+p_line_offset_nbits +: S],
        SRC,
        {N{1'b0}},
        req_in_msg[RQ-1 -: 3],
        SRC,
        req_in_msg[L+D+A +: O-S],
        req_in_msg[A+L+D-1:0]
    };

    // Response: route back to the requester ID carried in the opaque MSBs.
    assign respMsg_d = {
        resp_in_msg[L+D+O-1 -: S],
        SRC,
        {N{1'b0}},
        resp_in_msg
    };

    assign req_in_rdy   = !reqFull_q || req_out_rdy;
    assign req_out_val  = reqFull_q;
    assign req_out_msg  = reqMsg_q;
    assign resp_in_rdy  = !respFull_q || resp_out_rdy;
    assign resp_out_val = respFull_q;
    assign resp_out_msg = respMsg_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            reqFull_q <= 1'b0;
        end else if (req_in_val && req_in_rdy) begin
            reqFull_q <= 1'b1;
            reqMsg_q  <= reqMsg_d;
        end else if (req_out_val && req_out_rdy) begin
            reqFull_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            respFull_q <= 1'b0;
        end else if (resp_in_val && resp_in_rdy) begin
            respFull_q <= 1'b1;
            respMsg_q  <= respMsg_d;
        end else if (resp_out_val && resp_out_rdy) begin
            respFull_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcore_mem_net_adapter.sv
// Directed self-checking bench for mcore_mem_net_adapter with p_net_src = 2.
module tb_mcore_mem_net_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] reqInMsg;
    logic        reqInVal;
    logic        reqInRdy;
    logic [84:0] reqOutMsg;
    logic        reqOutVal;
    logic        reqOutRdy;
    logic [44:0] respInMsg;
    logic        respInVal;
    logic        respInRdy;
    logic [52:0] respOutMsg;
    logic        respOutVal;
    logic        respOutRdy;

    int compareCount = 0;
    int errorCount   = 0;

    always #5 clk = ~clk;

    mcore_mem_net_adapter #(.p_net_src(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_in_msg   (reqInMsg),
        .req_in_val   (reqInVal),
        .req_in_rdy   (reqInRdy),
        .req_out_msg  (reqOutMsg),
        .req_out_val  (reqOutVal),
        .req_out_rdy  (reqOutRdy),
        .resp_in_msg  (respInMsg),
        .resp_in_val  (respInVal),
        .resp_in_rdy  (respInRdy),
        .resp_out_msg (respOutMsg),
        .resp_out_val (respOutVal),
        .resp_out_rdy (respOutRdy)
    );

    function automatic logic [76:0] mkReq(input logic [2:0] t, input logic [7:0] opq,
                                          input logic [31:0] addr, input logic [1:0] len,
                                          input logic [31:0] data);
        return {t, opq, addr, len, data};
    endfunction

    function automatic logic [84:0] expReq(input logic [1:0] dest, input logic [2:0] t,
                                           input logic [7:0] opq, input logic [31:0] addr,
                                           input logic [1:0] len, input logic [31:0] data);
        return {dest, 2'd2, 4'd0, t, opq, addr, len, data};
    endfunction

    function automatic logic [44:0] mkResp(input logic [2:0] t, input logic [7:0] opq,
                                           input logic [1:0] len, input logic [31:0] data);
        return {t, opq, len, data};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rqVal, input logic [76:0] rqMsg,
                                 input logic rsVal, input logic [44:0] rsMsg);
        reqInVal  = rqVal;
        reqInMsg  = rqMsg;
        respInVal = rsVal;
        respInMsg = rsMsg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request per cycle with out_rdy high: value in, checked message out next cycle.
    task automatic reqBeat(input string tag, input logic [76:0] msg, input logic [84:0] exp);
        applyStimulus(1'b1, msg, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput({tag, ".val"}, 128'(reqOutVal), 128'(1'b1));
        checkOutput({tag, ".msg"}, 128'(reqOutMsg), 128'(exp));
    endtask

    task automatic respBeat(input string tag, input logic [44:0] msg, input logic [1:0] dest);
        applyStimulus(1'b0, '0, 1'b1, msg);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput({tag, ".val"}, 128'(respOutVal), 128'(1'b1));
        checkOutput({tag, ".msg"}, 128'(respOutMsg), 128'({dest, 2'd2, 4'd0, msg}));
    endtask

    initial begin
        logic [76:0] r [4];
        logic [84:0] e [4];

        reset      = 1'b0;
        reqOutRdy  = 1'b1;
        respOutRdy = 1'b1;
        applyStimulus(1'b1, mkReq(3'd0, 8'h01, 32'h1010, 2'd0, 32'h0), 1'b1, '0);
        tick();
        tick();
        checkOutput("rst.reqVal", 128'(reqOutVal), 128'(1'b0));
        checkOutput("rst.respVal", 128'(respOutVal), 128'(1'b0));
        applyStimulus(1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        #1;
        checkOutput("rst.reqRdy", 128'(reqInRdy), 128'(1'b1));
        checkOutput("rst.respRdy", 128'(respInRdy), 128'(1'b1));
        tick();
        checkOutput("rst.noAccept", 128'(reqOutVal), 128'(1'b0));

        reqBeat("rq0", mkReq(3'd0, 8'h00, 32'h00001010, 2'd0, 32'h0),
                expReq(2'd1, 3'd0, 8'h80, 32'h00001010, 2'd0, 32'h0));
        reqBeat("rq1", mkReq(3'd0, 8'h01, 32'h00001024, 2'd1, 32'h0),
                expReq(2'd2, 3'd0, 8'h81, 32'h00001024, 2'd1, 32'h0));
        reqBeat("rq2", mkReq(3'd0, 8'h02, 32'h00001008, 2'd2, 32'h0),
                expReq(2'd0, 3'd0, 8'h82, 32'h00001008, 2'd2, 32'h0));
        reqBeat("rq3", mkReq(3'd0, 8'h03, 32'h0000103c, 2'd3, 32'h0),
                expReq(2'd3, 3'd0, 8'h83, 32'h0000103c, 2'd3, 32'h0));
        reqBeat("wq0", mkReq(3'd1, 8'h10, 32'h00001070, 2'd0, 32'habcdef01),
                expReq(2'd3, 3'd1, 8'h90, 32'h00001070, 2'd0, 32'habcdef01));
        reqBeat("wq1", mkReq(3'd1, 8'h11, 32'h00001064, 2'd1, 32'h5a5a5a01),
                expReq(2'd2, 3'd1, 8'h91, 32'h00001064, 2'd1, 32'h5a5a5a01));
        reqBeat("wq2", mkReq(3'd1, 8'h12, 32'h00001068, 2'd2, 32'h3c3cef01),
                expReq(2'd2, 3'd1, 8'h92, 32'h00001068, 2'd2, 32'h3c3cef01));
        reqBeat("wq3", mkReq(3'd1, 8'h13, 32'h000010fc, 2'd3, 32'hc3cdef01),
                expReq(2'd3, 3'd1, 8'h93, 32'h000010fc, 2'd3, 32'hc3cdef01));
        tick();
        checkOutput("rq.drain", 128'(reqOutVal), 128'(1'b0));

        respBeat("rs0", mkResp(3'd0, 8'h00, 2'd0, 32'h11111111), 2'd0);
        respBeat("rs1", mkResp(3'd0, 8'hf1, 2'd1, 32'h22222222), 2'd3);
        respBeat("rs2", mkResp(3'd0, 8'h42, 2'd2, 32'h33333333), 2'd1);
        respBeat("rs3", mkResp(3'd0, 8'h83, 2'd3, 32'h44444444), 2'd2);
        respBeat("ws0", mkResp(3'd1, 8'h90, 2'd0, 32'habcdef01), 2'd2);
        respBeat("ws1", mkResp(3'd1, 8'h51, 2'd0, 32'h0), 2'd1);
        respBeat("ws2", mkResp(3'd1, 8'h52, 2'd0, 32'h0), 2'd1);
        respBeat("ws3", mkResp(3'd1, 8'h13, 2'd0, 32'h0), 2'd0);
        tick();
        checkOutput("rs.drain", 128'(respOutVal), 128'(1'b0));

        // Back-to-back stream: first output one cycle after first valid, no bubbles.
        r[0] = mkReq(3'd0, 8'h04, 32'h00002000, 2'd0, 32'h0);
        r[1] = mkReq(3'd0, 8'h05, 32'h00002010, 2'd0, 32'h0);
        r[2] = mkReq(3'd1, 8'h06, 32'h00002020, 2'd3, 32'h12345678);
        r[3] = mkReq(3'd1, 8'h07, 32'h00002030, 2'd2, 32'h9abcdef0);
        e[0] = expReq(2'd0, 3'd0, 8'h84, 32'h00002000, 2'd0, 32'h0);
        e[1] = expReq(2'd1, 3'd0, 8'h85, 32'h00002010, 2'd0, 32'h0);
        e[2] = expReq(2'd2, 3'd1, 8'h86, 32'h00002020, 2'd3, 32'h12345678);
        e[3] = expReq(2'd3, 3'd1, 8'h87, 32'h00002030, 2'd2, 32'h9abcdef0);
        applyStimulus(1'b1, r[0], 1'b0, '0);
        #1;
        checkOutput("stream.lat0", 128'(reqOutVal), 128'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) applyStimulus(1'b1, r[i+1], 1'b0, '0);
            else       applyStimulus(1'b0, '0, 1'b0, '0);
            checkOutput($sformatf("stream%0d.val", i), 128'(reqOutVal), 128'(1'b1));
            checkOutput($sformatf("stream%0d.msg", i), 128'(reqOutMsg), 128'(e[i]));
        end
        tick();
        checkOutput("stream.end", 128'(reqOutVal), 128'(1'b0));

        // Back-pressure: stored entry holds, input stalls, release swaps in the next message.
        reqOutRdy = 1'b0;
        applyStimulus(1'b1, r[0], 1'b0, '0);
        tick();
        applyStimulus(1'b1, r[1], 1'b0, '0);
        #1;
        checkOutput("bp.rdy", 128'(reqInRdy), 128'(1'b0));
        tick();
        checkOutput("bp.val", 128'(reqOutVal), 128'(1'b1));
        checkOutput("bp.hold", 128'(reqOutMsg), 128'(e[0]));
        reqOutRdy = 1'b1;
        #1;
        checkOutput("bp.release.rdy", 128'(reqInRdy), 128'(1'b1));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("bp.swap.val", 128'(reqOutVal), 128'(1'b1));
        checkOutput("bp.swap.msg", 128'(reqOutMsg), 128'(e[1]));
        tick();
        checkOutput("bp.empty", 128'(reqOutVal), 128'(1'b0));

        // Reset while full: stored message and the one presented during reset are dropped.
        reqOutRdy  = 1'b0;
        respOutRdy = 1'b0;
        applyStimulus(1'b1, r[2], 1'b1, mkResp(3'd0, 8'h80, 2'd0, 32'h77));
        tick();
        checkOutput("mid.reqFull", 128'(reqOutVal), 128'(1'b1));
        checkOutput("mid.respFull", 128'(respOutVal), 128'(1'b1));
        reset = 1'b0;
        applyStimulus(1'b1, r[3], 1'b1, mkResp(3'd0, 8'h40, 2'd0, 32'h88));
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("mid.reqVal", 128'(reqOutVal), 128'(1'b0));
        checkOutput("mid.respVal", 128'(respOutVal), 128'(1'b0));
        checkOutput("mid.reqRdy", 128'(reqInRdy), 128'(1'b1));
        checkOutput("mid.respRdy", 128'(respInRdy), 128'(1'b1));
        reqOutRdy  = 1'b1;
        respOutRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("mid.gone%0d", i), 128'(reqOutVal | respOutVal), 128'(1'b0));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
